// File: rtl/obstacle_motion_ctrl.sv
// Per-frame obstacle motion/animation sequencer writing x0, y0 and ctrl into a sprite core slot.
// Define OBSTACLE_AUTO_HIDE_EN to add bypass writes that hide/show the sprite around enable.
module obstacle_motion_ctrl #(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned V_TRIG   = 480,
    parameter int unsigned ANIM_DIV = 8,
    parameter int unsigned SPEED_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        x_i,
    input  logic [10:0]        y_i,
    input  logic               enable_i,
    input  logic [SPEED_W-1:0] speed_i,
    input  logic [10:0]        y_lane_i,
    input  logic               cpu_cs_i,
    input  logic               cpu_write_i,
    input  logic [13:0]        cpu_addr_i,
    input  logic [31:0]        cpu_wr_data_i,
    output logic               cs_o,
    output logic               write_o,
    output logic [13:0]        addr_o,
    output logic [31:0]        wr_data_o,
    output logic [10:0]        obs_x_o,
    output logic               wrap_pulse_o,
    output logic               busy_o
);

    localparam logic [10:0]     XReload = 11'(SCREEN_W - 1);
    localparam int unsigned     CntW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ANIM_DIV - 1);

    typedef enum logic [2:0] {
        StIdle, StCalc, StWrX0, StWrY0, StWrCtrl, StWrByp
    } state_e;

    state_e          state_q;
    logic [10:0]     pos_q;
    logic [1:0]      anim_q;
    logic [CntW-1:0] frame_cnt_q;
    logic            pending_q;

`ifdef OBSTACLE_AUTO_HIDE_EN
    logic enable_q;
    logic hide_req_q;
    logic byp_val_q;
`endif

    logic        tick;
    logic        grant;
    logic        start;
    logic        wrap;
    logic [10:0] speed_ext;

    assign tick      = (x_i == 11'd0) && (y_i == 11'(V_TRIG));
    assign grant     = !cpu_cs_i;
    assign start     = (tick || pending_q) && enable_i;
    assign speed_ext = 11'(speed_i);
    assign wrap      = (state_q == StCalc) && (pos_q < speed_ext);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pos_q       <= XReload;
            anim_q      <= 2'd0;
            frame_cnt_q <= '0;
            pending_q   <= 1'b0;
`ifdef OBSTACLE_AUTO_HIDE_EN
            enable_q    <= 1'b0;
            hide_req_q  <= 1'b0;
            byp_val_q   <= 1'b0;
`endif
        end else begin
            if (tick && state_q != StIdle) begin
                pending_q <= 1'b1;
            end
`ifdef OBSTACLE_AUTO_HIDE_EN
            enable_q <= enable_i;
            if (enable_q && !enable_i) begin
                hide_req_q <= 1'b1;
            end
`endif
            case (state_q)
                StIdle: begin
`ifdef OBSTACLE_AUTO_HIDE_EN
                    // A queued hide runs before any new motion sequence.
                    if (hide_req_q) begin
                        hide_req_q <= 1'b0;
                        byp_val_q  <= 1'b1;
                        state_q    <= StWrByp;
                    end else
`endif
                    if (start) begin
                        pending_q <= 1'b0;
                        state_q   <= StCalc;
                    end
                end
                StCalc: begin
                    pos_q <= wrap ? XReload : pos_q - speed_ext;
                    if (frame_cnt_q == CntLast) begin
                        frame_cnt_q <= '0;
                        anim_q      <= anim_q + 2'd1;
                    end else begin
                        frame_cnt_q <= frame_cnt_q + CntW'(1);
                    end
                    state_q <= StWrX0;
                end
                StWrX0:   if (grant) state_q <= StWrY0;
                StWrY0:   if (grant) state_q <= StWrCtrl;
                StWrCtrl: begin
                    if (grant) begin
`ifdef OBSTACLE_AUTO_HIDE_EN
                        byp_val_q <= 1'b0;
                        state_q   <= StWrByp;
`else
                        state_q   <= StIdle;
`endif
                    end
                end
                StWrByp:  if (grant) state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    logic        ctrl_cs;
    logic [13:0] ctrl_addr;
    logic [31:0] ctrl_data;

    always_comb begin
        ctrl_cs   = 1'b0;
        ctrl_addr = 14'h0000;
        ctrl_data = 32'h0;
        case (state_q)
            StWrX0: begin
                ctrl_cs   = 1'b1;
                ctrl_addr = 14'h2001;
                ctrl_data = {21'b0, pos_q};
            end
            StWrY0: begin
                ctrl_cs   = 1'b1;
                ctrl_addr = 14'h2002;
                ctrl_data = {21'b0, y_lane_i};
            end
            StWrCtrl: begin
                ctrl_cs   = 1'b1;
                ctrl_addr = 14'h2003;
                ctrl_data = {27'b0, 3'b001, anim_q};
            end
`ifdef OBSTACLE_AUTO_HIDE_EN
            StWrByp: begin
                ctrl_cs   = 1'b1;
                ctrl_addr = 14'h2000;
                ctrl_data = {31'b0, byp_val_q};
            end
`endif
            default: ;
        endcase
    end

    // CPU owns the bus whenever it selects; the controller simply holds its state.
    always_comb begin
        if (cpu_cs_i) begin
            cs_o      = cpu_cs_i;
            write_o   = cpu_write_i;
            addr_o    = cpu_addr_i;
            wr_data_o = cpu_wr_data_i;
        end else begin
            cs_o      = ctrl_cs;
            write_o   = ctrl_cs;
            addr_o    = ctrl_addr;
            wr_data_o = ctrl_data;
        end
    end

    assign obs_x_o      = pos_q;
    assign wrap_pulse_o = wrap;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_obstacle_motion_ctrl.sv
// Directed, table-driven bench for obstacle_motion_ctrl (default build).
module tb_obstacle_motion_ctrl;

    logic        clk;
    logic        reset;
    logic [10:0] x;
    logic [10:0] y;
    logic        enable;
    logic [3:0]  speed;
    logic [10:0] y_lane;
    logic        cpu_cs;
    logic        cpu_write;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic        cs;
    logic        write;
    logic [13:0] addr;
    logic [31:0] wr_data;
    logic [10:0] obs_x;
    logic        wrap_pulse;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    obstacle_motion_ctrl #(
        .SCREEN_W(640),
        .V_TRIG  (480),
        .ANIM_DIV(8),
        .SPEED_W (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .x_i          (x),
        .y_i          (y),
        .enable_i     (enable),
        .speed_i      (speed),
        .y_lane_i     (y_lane),
        .cpu_cs_i     (cpu_cs),
        .cpu_write_i  (cpu_write),
        .cpu_addr_i   (cpu_addr),
        .cpu_wr_data_i(cpu_wr_data),
        .cs_o         (cs),
        .write_o      (write),
        .addr_o       (addr),
        .wr_data_o    (wr_data),
        .obs_x_o      (obs_x),
        .wrap_pulse_o (wrap_pulse),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Raises one frame tick in the current cycle (k=0) and follows the sequence until idle.
    task automatic run_frame(input logic en, input logic [3:0] sp, input logic [10:0] lane,
                             input int cpu_lo, input int cpu_hi,
                             output logic [31:0] dx, output logic [31:0] dy,
                             output logic [31:0] dc, output int nw, output int wraps,
                             output int cx, output int cc, output int cpu_ok);
        logic done;
        dx = 0; dy = 0; dc = 0; nw = 0; wraps = 0; cx = -1; cc = -1; cpu_ok = 1;
        done = 1'b0;
        enable = en; speed = sp; y_lane = lane; x = 11'd0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            x = 11'd1;
            cpu_cs = (k >= cpu_lo) && (k <= cpu_hi);
            cpu_write = cpu_cs;
            #1;
            if (cpu_cs) begin
                if (cs !== 1'b1 || write !== 1'b1 || addr !== 14'h2000 ||
                    wr_data !== 32'hdead_beef) cpu_ok = 0;
            end else if (cs && write) begin
                nw++;
                if (addr == 14'h2001) begin dx = wr_data; cx = k; end
                if (addr == 14'h2002) dy = wr_data;
                if (addr == 14'h2003) begin dc = wr_data; cc = k; end
            end
            if (wrap_pulse) wraps++;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        cpu_cs = 1'b0; cpu_write = 1'b0;
        chk("frame_done", 32'(done), 32'd1);
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  sp;
        logic [10:0] lane;
        int          cpu_lo;
        int          cpu_hi;
        int          exp_nw;
        logic [31:0] exp_x0;
        logic [31:0] exp_y0;
        logic [31:0] exp_ctrl;
        int          exp_wraps;
        int          exp_cx;
        int          exp_cc;
        logic [10:0] exp_obs;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] dx, dy, dc;
        int nw, wraps, cx, cc, cpu_ok;
        int n;
        int nx, c1, c2, nctrl;
        logic [31:0] last_x0;
        logic b25, b4, cs4, y0_seen;
        logic [10:0] obs4;

        tbl[0] = '{1'b1, 4'd4,  11'd400,  0, -1, 3, 32'd635, 32'd400,  32'd4, 0, 2, 4, 11'd635};
        tbl[1] = '{1'b1, 4'd0,  11'd12,   0, -1, 3, 32'd635, 32'd12,   32'd4, 0, 2, 4, 11'd635};
        tbl[2] = '{1'b1, 4'd15, 11'd2047, 0, -1, 3, 32'd620, 32'd2047, 32'd4, 0, 2, 4, 11'd620};
        tbl[3] = '{1'b1, 4'd10, 11'd7,    0, -1, 3, 32'd610, 32'd7,    32'd4, 0, 2, 4, 11'd610};
        tbl[4] = '{1'b1, 4'd1,  11'd100,  2,  4, 3, 32'd609, 32'd100,  32'd4, 0, 5, 7, 11'd609};
        tbl[5] = '{1'b1, 4'd1,  11'd1,    0, -1, 3, 32'd608, 32'd1,    32'd4, 0, 2, 4, 11'd608};
        tbl[6] = '{1'b1, 4'd1,  11'd2,    0, -1, 3, 32'd607, 32'd2,    32'd4, 0, 2, 4, 11'd607};
        tbl[7] = '{1'b1, 4'd1,  11'd3,    0, -1, 3, 32'd606, 32'd3,    32'd5, 0, 2, 4, 11'd606};
        tbl[8] = '{1'b0, 4'd5,  11'd9,    0, -1, 0, 32'd0,   32'd0,    32'd0, 0, -1, -1, 11'd606};

        reset = 1'b1; x = 11'd1; y = 11'd480; enable = 1'b0; speed = 4'd0; y_lane = 11'd0;
        cpu_cs = 1'b0; cpu_write = 1'b0; cpu_addr = 14'h2000; cpu_wr_data = 32'hdead_beef;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_obs_x", 32'(obs_x), 32'd639);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wrap", 32'(wrap_pulse), 32'd0);
        chk("rst_cs", 32'(cs), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_frame(tbl[i].en, tbl[i].sp, tbl[i].lane, tbl[i].cpu_lo, tbl[i].cpu_hi,
                      dx, dy, dc, nw, wraps, cx, cc, cpu_ok);
            chk($sformatf("v%0d_writes", i), 32'(nw), 32'(tbl[i].exp_nw));
            chk($sformatf("v%0d_x0", i), dx, tbl[i].exp_x0);
            chk($sformatf("v%0d_y0", i), dy, tbl[i].exp_y0);
            chk($sformatf("v%0d_ctrl", i), dc, tbl[i].exp_ctrl);
            chk($sformatf("v%0d_wraps", i), 32'(wraps), 32'(tbl[i].exp_wraps));
            chk($sformatf("v%0d_x0_cycle", i), 32'(cx), 32'(tbl[i].exp_cx));
            chk($sformatf("v%0d_ctrl_cycle", i), 32'(cc), 32'(tbl[i].exp_cc));
            chk($sformatf("v%0d_cpu_pass", i), 32'(cpu_ok), 32'd1);
            chk($sformatf("v%0d_obs_x", i), 32'(obs_x), 32'(tbl[i].exp_obs));
        end

        // Long run: position steps down by 15, anim index = (frames/8) mod 4.
        n = 8;
        for (int i = 1; i <= 40; i++) begin
            run_frame(1'b1, 4'd15, 11'd50, 0, -1, dx, dy, dc, nw, wraps, cx, cc, cpu_ok);
            n++;
            chk($sformatf("run%0d_x0", i), dx, 32'(606 - 15 * i));
            chk($sformatf("run%0d_ctrl", i), dc, 32'(4 + ((n / 8) % 4)));
        end
        run_frame(1'b1, 4'd3, 11'd50, 0, -1, dx, dy, dc, nw, wraps, cx, cc, cpu_ok);
        n++;
        chk("pre_wrap_x0", dx, 32'd3);
        run_frame(1'b1, 4'd4, 11'd50, 0, -1, dx, dy, dc, nw, wraps, cx, cc, cpu_ok);
        n++;
        chk("wrap_x0", dx, 32'd639);
        chk("wrap_pulses", 32'(wraps), 32'd1);
        chk("wrap_obs_x", 32'(obs_x), 32'd639);
        chk("wrap_ctrl", dc, 32'(4 + ((n / 8) % 4)));
        run_frame(1'b1, 4'd4, 11'd50, 0, -1, dx, dy, dc, nw, wraps, cx, cc, cpu_ok);
        chk("post_wrap_x0", dx, 32'd635);
        chk("post_wrap_pulses", 32'(wraps), 32'd0);

        // Pending: CPU stalls k=2..9, ticks at k=3 (queued) and k=6 (dropped).
        nx = 0; c1 = -1; c2 = -1; last_x0 = 0; b25 = 1'b1;
        enable = 1'b1; speed = 4'd1; x = 11'd0;
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk); #1;
            x = (k == 3 || k == 6) ? 11'd0 : 11'd1;
            cpu_cs = (k >= 2) && (k <= 9);
            cpu_write = cpu_cs;
            #1;
            if (!cpu_cs && cs && write && addr == 14'h2001) begin
                nx++;
                if (nx == 1) c1 = k;
                else c2 = k;
                last_x0 = wr_data;
            end
            if (k == 25) b25 = busy;
        end
        cpu_cs = 1'b0; cpu_write = 1'b0; x = 11'd1;
        chk("pend_x0_writes", 32'(nx), 32'd2);
        chk("pend_first_cycle", 32'(c1), 32'd10);
        chk("pend_second_cycle", 32'(c2), 32'd15);
        chk("pend_last_x0", last_x0, 32'd633);
        chk("pend_idle_after", 32'(b25), 32'd0);

        // Reset during WR_Y0 aborts the sequence.
        nctrl = 0; b4 = 1'b1; cs4 = 1'b1; obs4 = 11'd0; y0_seen = 1'b0;
        speed = 4'd2; x = 11'd0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            x = 11'd1;
            reset = (k == 3);
            #1;
            if (k == 3) y0_seen = (cs && write && addr == 14'h2002);
            if (cs && write && addr == 14'h2003) nctrl++;
            if (k == 4) begin b4 = busy; cs4 = cs; obs4 = obs_x; end
        end
        reset = 1'b0;
        chk("rstmid_y0_seen", 32'(y0_seen), 32'd1);
        chk("rstmid_ctrl_writes", 32'(nctrl), 32'd0);
        chk("rstmid_busy", 32'(b4), 32'd0);
        chk("rstmid_cs", 32'(cs4), 32'd0);
        chk("rstmid_obs_x", 32'(obs4), 32'd639);
        run_frame(1'b1, 4'd4, 11'd400, 0, -1, dx, dy, dc, nw, wraps, cx, cc, cpu_ok);
        chk("after_rst_x0", dx, 32'd635);
        chk("after_rst_ctrl", dc, 32'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
